// File: rtl/counter_ctrl_pkg.sv
// Shared types for the commandable event counter: opcodes, run state, grant index width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package counter_ctrl_pkg;

  // Command opcodes carried on req_op, two bits per requester.
  typedef enum logic [1:0] {
    OP_CLEAR = 2'd0,
    OP_LOAD  = 2'd1,
    OP_START = 2'd2,
    OP_STOP  = 2'd3
  } op_e;

  // Run/stop state of the counter.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Encoded requester index width; covers up to 8 requesters.
  localparam int GRANT_ID_W = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the rotating pointer.
// Latency: grant is combinational from req_i; pointer updates on the clock edge after an accept.
// Backpressure: pointer holds when advance_i is low, so an unserved requester keeps its priority.
module rr_arbiter
  import counter_ctrl_pkg::*;
#(
  parameter int REQ_N = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REQ_N-1:0]      req_i,
  input  logic                  advance_i,
  output logic [REQ_N-1:0]      gnt_o,
  output logic [GRANT_ID_W-1:0] idx_o
);

  logic [GRANT_ID_W-1:0] ptr_q;
  logic [GRANT_ID_W-1:0] ptr_d;
  logic [GRANT_ID_W-1:0] nxt_ptr;
  logic                  found_hi;
  logic                  found_any;

  // Pick the first active request from the pointer upward, else the lowest one below it.
  always_comb begin
    gnt_o     = '0;
    idx_o     = '0;
    nxt_ptr   = '0;
    found_hi  = 1'b0;
    found_any = 1'b0;
    for (int i = 0; i < REQ_N; i++) begin
      if (!found_hi && req_i[i] && (i >= int'(ptr_q))) begin
        found_hi = 1'b1;
        gnt_o    = '0;
        gnt_o[i] = 1'b1;
        idx_o    = GRANT_ID_W'(i);
        nxt_ptr  = (i == REQ_N - 1) ? '0 : GRANT_ID_W'(i + 1);
      end
    end
    found_any = found_hi;
    for (int i = 0; i < REQ_N; i++) begin
      if (!found_any && req_i[i]) begin
        found_any = 1'b1;
        gnt_o     = '0;
        gnt_o[i]  = 1'b1;
        idx_o     = GRANT_ID_W'(i);
        nxt_ptr   = (i == REQ_N - 1) ? '0 : GRANT_ID_W'(i + 1);
      end
    end
    ptr_d = advance_i ? nxt_ptr : ptr_q;
  end

  // Rotating priority pointer; moves past the winner only when its command is taken.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/counter_cmd_arbiter.sv
// Shared event counter with round-robin command arbitration (CLEAR/LOAD/START/STOP); COUNTER_CMP_EN adds compare pulse.
// Latency: accepted command applied at the accepting edge, visible on out/running one cycle later.
// Backpressure: one command per cycle, req_ready one-hot to the rr winner; every valid is served within REQ_N cycles.
module counter_cmd_arbiter
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int REQ_N      = 2,
  parameter int PRESCALE_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REQ_N-1:0]       req_valid,
  output logic [REQ_N-1:0]       req_ready,
  input  logic [2*REQ_N-1:0]     req_op,
  input  logic [WIDTH*REQ_N-1:0] req_data,
  input  logic [PRESCALE_W-1:0]  cfg_prescale,
  input  logic [WIDTH-1:0]       cmp_val,
  output logic [WIDTH-1:0]       out,
  output logic                   running,
  output logic [GRANT_ID_W-1:0]  grant_id,
  output logic                   wrap,
  output logic                   cmp_hit
);

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      out_q, out_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [GRANT_ID_W-1:0] grant_id_q, grant_id_d;
  logic                  wrap_q, wrap_d;

  logic [REQ_N-1:0]      arb_gnt;
  logic [GRANT_ID_W-1:0] arb_idx;
  logic                  cmd_vld;
  op_e                   cmd_op;
  logic [WIDTH-1:0]      cmd_data;
  logic                  inc_due;
  logic                  do_inc;
  logic                  wrote;

  // Reset forces ready low so nothing is accepted and the pointer is not advanced on that edge.
  assign req_ready = arb_gnt & {REQ_N{~rst}};
  assign cmd_vld   = |req_ready;

  rr_arbiter #(
    .REQ_N(REQ_N)
  ) u_arb (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (req_valid),
    .advance_i(cmd_vld),
    .gnt_o    (arb_gnt),
    .idx_o    (arb_idx)
  );

  // Mux the winning requester's opcode and load value.
  always_comb begin
    cmd_op   = OP_CLEAR;
    cmd_data = '0;
    for (int i = 0; i < REQ_N; i++) begin
      if (req_ready[i]) begin
        cmd_op   = op_e'(req_op[2*i +: 2]);
        cmd_data = req_data[WIDTH*i +: WIDTH];
      end
    end
  end

  // Next state: prescaled increment in RUN, then the accepted command overrides it where they collide.
  always_comb begin
    state_d    = state_q;
    out_d      = out_q;
    presc_d    = presc_q;
    grant_id_d = grant_id_q;
    inc_due    = 1'b0;
    wrote      = 1'b0;

    if (state_q == ST_RUN) begin
      inc_due = (presc_q == cfg_prescale);
      // A prescaler above a freshly lowered cfg_prescale free-runs to max and wraps without counting.
      presc_d = inc_due ? '0 : presc_q + 1'b1;
    end
    do_inc = inc_due;

    if (cmd_vld) begin
      grant_id_d = arb_idx;
      case (cmd_op)
        OP_CLEAR: begin
          out_d   = '0;
          presc_d = '0;
          do_inc  = 1'b0;
          wrote   = 1'b1;
        end
        OP_LOAD: begin
          out_d   = cmd_data;
          presc_d = '0;
          do_inc  = 1'b0;
          wrote   = 1'b1;
        end
        OP_START: begin
          // Restarting from IDLE begins a fresh prescale period; START while running changes nothing.
          if (state_q == ST_IDLE) begin
            state_d = ST_RUN;
            presc_d = '0;
          end
        end
        OP_STOP: begin
          if (state_q == ST_RUN) begin
            state_d = ST_IDLE;
            presc_d = presc_q;
            do_inc  = 1'b0;
          end
        end
      endcase
    end

    if (do_inc) begin
      out_d = out_q + 1'b1;
    end
    wrap_d = do_inc && (&out_q);
  end

  // State register, count, prescaler and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      out_q      <= '0;
      presc_q    <= '0;
      grant_id_q <= '0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      presc_q    <= presc_d;
      grant_id_q <= grant_id_d;
      wrap_q     <= wrap_d;
    end
  end

  assign out      = out_q;
  assign running  = (state_q == ST_RUN);
  assign grant_id = grant_id_q;
  assign wrap     = wrap_q;

`ifdef COUNTER_CMP_EN
  logic cmp_hit_q;

  // Pulse only when the count actually moves onto the compare value, not while it sits there.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_hit_q <= 1'b0;
    end else begin
      cmp_hit_q <= (do_inc || wrote) && (out_d != out_q) && (out_d == cmp_val);
    end
  end

  assign cmp_hit = cmp_hit_q;
`else
  logic unused_cmp_val;

  assign unused_cmp_val = ^cmp_val;
  assign cmp_hit        = 1'b0;
`endif

endmodule

// File: tb/tb_counter_cmd_arbiter.sv
// Directed, table-driven bench for counter_cmd_arbiter (REQ_N=2, WIDTH=32).
// Each table row is one clock: drive at negedge, check req_ready before the edge, outputs after it.
// Extra hand-written sequences cover prescale timing and, with COUNTER_CMP_EN, the compare pulse.
module tb_counter_cmd_arbiter;

  localparam int WIDTH      = 32;
  localparam int REQ_N      = 2;
  localparam int PRESCALE_W = 8;

  localparam logic [1:0] CLR = 2'd0;
  localparam logic [1:0] LD  = 2'd1;
  localparam logic [1:0] STA = 2'd2;
  localparam logic [1:0] STO = 2'd3;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [REQ_N-1:0]       req_valid;
  logic [REQ_N-1:0]       req_ready;
  logic [2*REQ_N-1:0]     req_op;
  logic [WIDTH*REQ_N-1:0] req_data;
  logic [PRESCALE_W-1:0]  cfg_prescale;
  logic [WIDTH-1:0]       cmp_val;
  logic [WIDTH-1:0]       out;
  logic                   running;
  logic [2:0]             grant_id;
  logic                   wrap;
  logic                   cmp_hit;

  int checks = 0;
  int errors = 0;

  counter_cmd_arbiter #(
    .WIDTH(WIDTH), .REQ_N(REQ_N), .PRESCALE_W(PRESCALE_W)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_data(req_data), .cfg_prescale(cfg_prescale),
    .cmp_val(cmp_val), .out(out), .running(running), .grant_id(grant_id),
    .wrap(wrap), .cmp_hit(cmp_hit)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [1:0]  vld;
    logic [1:0]  op0;
    logic [1:0]  op1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [7:0]  presc;
    logic [1:0]  rdy;
    logic [31:0] out;
    logic        run;
    logic [2:0]  gid;
    logic        wrap;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [1:0] v, input logic [1:0] o0, input logic [1:0] o1,
                     input logic [31:0] d0, input logic [31:0] d1, input logic [7:0] p,
                     input logic [1:0] rdy, input logic [31:0] o, input logic run,
                     input logic [2:0] gid, input logic w);
    vec_t t;
    t.rst = r; t.vld = v; t.op0 = o0; t.op1 = o1; t.d0 = d0; t.d1 = d1; t.presc = p;
    t.rdy = rdy; t.out = o; t.run = run; t.gid = gid; t.wrap = w;
    vecs.push_back(t);
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] o0, input logic [1:0] o1,
                       input logic [31:0] d0, input logic [31:0] d1);
    req_valid = v;
    req_op    = {o1, o0};
    req_data  = {d1, d0};
  endtask

  initial begin
    int n;
    int hits;
    logic [31:0] hit_out;

    rst = 1'b1; cfg_prescale = '0; cmp_val = '0;
    drive(2'b00, CLR, CLR, 32'h0, 32'h0);

    //  rst vld   op0  op1  d0            d1           psc  rdy    out           run gid wrap
    add(1, 2'b00, CLR, CLR, 32'h0,        32'h0,       0, 2'b00, 32'h0,        0, 0, 0); // reset
    add(0, 2'b01, STA, CLR, 32'h0,        32'h0,       0, 2'b01, 32'h0,        1, 0, 0); // START r0
    add(0, 2'b00, CLR, CLR, 32'h0,        32'h0,       0, 2'b00, 32'h1,        1, 0, 0);
    add(0, 2'b00, CLR, CLR, 32'h0,        32'h0,       0, 2'b00, 32'h2,        1, 0, 0);
    add(0, 2'b00, CLR, CLR, 32'h0,        32'h0,       0, 2'b00, 32'h3,        1, 0, 0);
    add(0, 2'b11, STA, STA, 32'h0,        32'h0,       0, 2'b10, 32'h4,        1, 1, 0); // rr alternation
    add(0, 2'b11, STA, STA, 32'h0,        32'h0,       0, 2'b01, 32'h5,        1, 0, 0);
    add(0, 2'b11, STA, STA, 32'h0,        32'h0,       0, 2'b10, 32'h6,        1, 1, 0);
    add(0, 2'b11, STA, STA, 32'h0,        32'h0,       0, 2'b01, 32'h7,        1, 0, 0);
    add(0, 2'b01, LD,  CLR, 32'hFFFFFFFE, 32'h0,       0, 2'b01, 32'hFFFFFFFE, 1, 0, 0); // LOAD beats inc
    add(0, 2'b00, CLR, CLR, 32'h0,        32'h0,       0, 2'b00, 32'hFFFFFFFF, 1, 0, 0);
    add(0, 2'b00, CLR, CLR, 32'h0,        32'h0,       0, 2'b00, 32'h0,        1, 0, 1); // wrap
    add(0, 2'b00, CLR, CLR, 32'h0,        32'h0,       0, 2'b00, 32'h1,        1, 0, 0);
    add(0, 2'b10, CLR, STO, 32'h0,        32'h0,       0, 2'b10, 32'h1,        0, 1, 0); // STOP, no inc
    add(0, 2'b00, CLR, CLR, 32'h0,        32'h0,       0, 2'b00, 32'h1,        0, 1, 0);
    add(0, 2'b10, CLR, STO, 32'h0,        32'h0,       0, 2'b10, 32'h1,        0, 1, 0); // STOP in IDLE
    add(0, 2'b01, CLR, CLR, 32'h0,        32'h0,       0, 2'b01, 32'h0,        0, 0, 0); // CLEAR in IDLE
    add(0, 2'b01, STA, CLR, 32'h0,        32'h0,       3, 2'b01, 32'h0,        1, 0, 0); // START psc=3
    add(0, 2'b00, CLR, CLR, 32'h0,        32'h0,       3, 2'b00, 32'h0,        1, 0, 0);
    add(0, 2'b00, CLR, CLR, 32'h0,        32'h0,       3, 2'b00, 32'h0,        1, 0, 0);
    add(0, 2'b00, CLR, CLR, 32'h0,        32'h0,       3, 2'b00, 32'h0,        1, 0, 0);
    add(0, 2'b00, CLR, CLR, 32'h0,        32'h0,       3, 2'b00, 32'h1,        1, 0, 0); // 4th edge
    add(0, 2'b00, CLR, CLR, 32'h0,        32'h0,       3, 2'b00, 32'h1,        1, 0, 0);
    add(0, 2'b00, CLR, CLR, 32'h0,        32'h0,       3, 2'b00, 32'h1,        1, 0, 0);
    add(0, 2'b00, CLR, CLR, 32'h0,        32'h0,       3, 2'b00, 32'h1,        1, 0, 0);
    add(0, 2'b01, CLR, CLR, 32'h0,        32'h0,       3, 2'b01, 32'h0,        1, 0, 0); // CLEAR on due edge
    add(0, 2'b00, CLR, CLR, 32'h0,        32'h0,       3, 2'b00, 32'h0,        1, 0, 0);
    add(0, 2'b00, CLR, CLR, 32'h0,        32'h0,       3, 2'b00, 32'h0,        1, 0, 0);
    add(0, 2'b00, CLR, CLR, 32'h0,        32'h0,       3, 2'b00, 32'h0,        1, 0, 0);
    add(0, 2'b00, CLR, CLR, 32'h0,        32'h0,       3, 2'b00, 32'h1,        1, 0, 0); // 4 after CLEAR
    add(1, 2'b10, CLR, LD,  32'h0,        32'h1234,    3, 2'b00, 32'h0,        0, 0, 0); // rst + LOAD
    add(0, 2'b11, STO, STO, 32'h0,        32'h0,       0, 2'b01, 32'h0,        0, 0, 0); // ptr back at 0
    add(0, 2'b00, CLR, CLR, 32'h0,        32'h0,       0, 2'b00, 32'h0,        0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst;
      cfg_prescale = vecs[i].presc;
      drive(vecs[i].vld, vecs[i].op0, vecs[i].op1, vecs[i].d0, vecs[i].d1);
      #1;
      chk($sformatf("row%0d req_ready", i), 32'(req_ready), 32'(vecs[i].rdy));
      chk($sformatf("row%0d ready_onehot0", i), 32'($onehot0(req_ready)), 32'd1);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d out", i), out, vecs[i].out);
      chk($sformatf("row%0d running", i), 32'(running), 32'(vecs[i].run));
      chk($sformatf("row%0d grant_id", i), 32'(grant_id), 32'(vecs[i].gid));
      chk($sformatf("row%0d wrap", i), 32'(wrap), 32'(vecs[i].wrap));
`ifndef COUNTER_CMP_EN
      chk($sformatf("row%0d cmp_hit", i), 32'(cmp_hit), 32'd0);
`endif
    end

    // Prescale 1 from IDLE (out=0, pointer=1): out reaches 3 six edges after the accept.
    @(negedge clk);
    rst = 1'b0; cfg_prescale = 8'd1;
    drive(2'b01, STA, CLR, 32'h0, 32'h0);
    @(posedge clk); #1;
    chk("psc1 running", 32'(running), 32'd1);
    @(negedge clk);
    drive(2'b00, CLR, CLR, 32'h0, 32'h0);
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (out == 32'd3) break;
    end
    chk("psc1 edges_to_3", 32'(n), 32'd6);
    @(negedge clk);
    drive(2'b01, STO, CLR, 32'h0, 32'h0);
    @(posedge clk); #1;
    chk("psc1 stop running", 32'(running), 32'd0);
    chk("psc1 stop out", out, 32'd3);

`ifdef COUNTER_CMP_EN
    // Compare pulse: clear, run to 10 with cmp_val=5, then load 5 and hold.
    @(negedge clk);
    cfg_prescale = 8'd0; cmp_val = 32'd5;
    drive(2'b01, CLR, CLR, 32'h0, 32'h0);
    @(posedge clk); #1;
    chk("cmp clear no_pulse", 32'(cmp_hit), 32'd0);
    @(negedge clk);
    drive(2'b01, STA, CLR, 32'h0, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    drive(2'b00, CLR, CLR, 32'h0, 32'h0);
    hits = 0; hit_out = '0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (cmp_hit) begin
        hits++;
        hit_out = out;
      end
    end
    chk("cmp run hits", 32'(hits), 32'd1);
    chk("cmp run hit_out", hit_out, 32'd5);
    @(negedge clk);
    drive(2'b01, STO, CLR, 32'h0, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    drive(2'b01, LD, CLR, 32'd5, 32'h0);
    @(posedge clk); #1;
    chk("cmp load5 pulse", 32'(cmp_hit), 32'd1);
    @(negedge clk);
    drive(2'b00, CLR, CLR, 32'h0, 32'h0);
    hits = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (cmp_hit) hits++;
    end
    chk("cmp hold hits", 32'(hits), 32'd0);
    chk("cmp hold out", out, 32'd5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_cmd_arbiter.md
Name: counter_cmd_arbiter

Overview:
- Controller and scheduler for the free-running 32-bit event counter in the DUT partition.
- Turns it into a shared, commandable resource: REQ_N requesters issue CLEAR/LOAD/START/STOP over valid/ready handshakes.
- A round-robin arbiter grants one command per cycle. The block owns the count register, a prescaler and the run/stop state machine.
- Output feeds the same consumers as the plain counter's 32-bit out bus.

Parameters:
- WIDTH, 32, counter width in bits.
- REQ_N, 2, number of command requesters (range 1..8).
- PRESCALE_W, 8, width of the prescale divider field.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  REQ_N  per-requester command valid.
- req_ready  output  REQ_N  per-requester accept (one-hot or zero).
- req_op  input  2*REQ_N  per-requester opcode, requester i at bits [2i+1:2i]; 0 CLEAR, 1 LOAD, 2 START, 3 STOP.
- req_data  input  WIDTH*REQ_N  per-requester LOAD value, requester i at [WIDTH*i +: WIDTH].
- cfg_prescale  input  PRESCALE_W  increment once every cfg_prescale+1 enabled cycles.
- cmp_val  input  WIDTH  compare value (used only with the optional feature).
- out  output  WIDTH  current count.
- running  output  1  high in RUN state.
- grant_id  output  3  index of the last accepted requester.
- wrap  output  1  one-cycle pulse when count wraps all-ones to 0.
- cmp_hit  output  1  one-cycle compare-match pulse (optional feature).

Behaviour:
- Reset (sync, rst=1 at posedge): out=0, state=IDLE, running=0, prescaler=0, rr pointer=0, grant_id=0, wrap=0, cmp_hit=0, req_ready=0.
- req_ready is combinational. In a given cycle, at most one bit is high: the requester with valid high that is first from the rr pointer.
- A command is accepted when req_valid[i] and req_ready[i] are both high at the posedge. The rr pointer then moves to i+1 mod REQ_N.
- No valid means no grant, and the pointer holds.
- req_ready does not depend on state. Every command is always accepted within REQ_N cycles.
- Effect latency: the command is applied at the accepting edge and is visible on out/running the next cycle.
- State machine:
  - IDLE to RUN on START.
  - RUN to IDLE on STOP.
  - START in RUN is a no-op; the prescaler is not reset.
  - STOP in IDLE is a no-op.
  - CLEAR and LOAD are legal in both states and do not change state.
- CLEAR: out←0 and prescaler←0.
- LOAD: out←req_data of the granted requester, and prescaler←0.
- Increment (RUN only):
  - Each cycle, prescaler increments.
  - When prescaler==cfg_prescale, out←out+1 (mod 2^WIDTH) and prescaler←0.
  - cfg_prescale=0 gives +1 every cycle.
- Simultaneous events:
  - CLEAR or LOAD on the same edge as a due increment: the command wins and the increment is dropped.
  - STOP on an increment edge: no increment.
  - START from IDLE: the first increment occurs cfg_prescale+1 cycles after the accept edge.
- Wrap: an increment from all-ones gives out=0 and wrap=1 for exactly one cycle. LOAD/CLEAR to 0 do not pulse wrap.
- A cfg_prescale change mid-run takes effect at the next compare. If prescaler > new value, the prescaler runs to max and wraps to 0 with no increment.
- Reset asserted mid-operation overrides all commands on that edge.

Optional Feature:
- Macro COUNTER_CMP_EN.
- Defined: cmp_hit pulses one cycle when out changes, by increment, LOAD or CLEAR, to a value equal to cmp_val. No pulse while out merely holds an equal value.
- Undefined: cmp_hit tied to 0 and cmp_val unused; no compare logic is generated.

Decomposition:
- Package counter_ctrl_pkg: op enum (OP_CLEAR=0, OP_LOAD=1, OP_START=2, OP_STOP=3), state enum (ST_IDLE, ST_RUN), grant_id width constant 3.
- Sub-module rr_arbiter (REQ_N param): inputs req, advance; outputs one-hot gnt and an encoded index. It holds the rotating pointer.

Test Plan:
- Reset, then START from requester 0 with cfg_prescale=0 → running=1 next cycle; out=1,2,3 on successive cycles.
- Requesters 0 and 1 both valid with STOP/START held for 4 cycles → grants alternate 0,1,0,1; grant_id follows; no cycle has two ready bits.
- LOAD 0xFFFF_FFFE, RUN, prescale 0 → out FFFFFFFF then 0; wrap high exactly on the 0 cycle.
- cfg_prescale=3 in RUN → out increments every 4 cycles; CLEAR on a due edge → out=0 with no increment; the next increment comes 4 cycles later.
- rst asserted mid-RUN with a LOAD pending → all outputs at reset values next cycle; LOAD discarded; rr pointer=0.
- COUNTER_CMP_EN, cmp_val=5, run from 0 → cmp_hit one cycle when out=5. Then STOP holding out=5 → no further pulses.
